// File: rtl/ibex_md_issue_ctrl.sv
// Issue/writeback controller in front of ibex_multdiv_fast: latches one RV32M
// request, holds the multdiv enables and imd_val state, and buffers the result for writeback.
module ibex_md_issue_ctrl #(
    parameter int unsigned RdWidth    = 5,
    parameter bit          DropRdZero = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [2:0]         req_funct3_i,
    input  logic [31:0]        req_op_a_i,
    input  logic [31:0]        req_op_b_i,
    input  logic [RdWidth-1:0] req_rd_i,
    input  logic               flush_i,
    output logic               md_mult_en_o,
    output logic               md_div_en_o,
    output logic               md_mult_sel_o,
    output logic               md_div_sel_o,
    output logic [1:0]         md_operator_o,
    output logic [1:0]         md_signed_mode_o,
    output logic [31:0]        md_op_a_o,
    output logic [31:0]        md_op_b_o,
    input  logic [67:0]        md_imd_val_d_i,
    input  logic [1:0]         md_imd_val_we_i,
    output logic [67:0]        md_imd_val_q_o,
    output logic               md_ready_id_o,
    input  logic [31:0]        md_result_i,
    input  logic               md_valid_i,
    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic [RdWidth-1:0] wb_rd_o,
    output logic [31:0]        wb_data_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_e;

    // Returns {operator, signed_mode} for an RV32M funct3.
    function automatic logic [3:0] decode_funct3(input logic [2:0] f3);
        logic [3:0] dec;
        case (f3)
            3'b000:  dec = {2'd0, 2'b00};  // MUL
            3'b001:  dec = {2'd1, 2'b11};  // MULH
            3'b010:  dec = {2'd1, 2'b01};  // MULHSU
            3'b011:  dec = {2'd1, 2'b00};  // MULHU
            3'b100:  dec = {2'd2, 2'b11};  // DIV
            3'b101:  dec = {2'd2, 2'b00};  // DIVU
            3'b110:  dec = {2'd3, 2'b11};  // REM
            3'b111:  dec = {2'd3, 2'b00};  // REMU
            default: dec = 4'b0000;
        endcase
        return dec;
    endfunction

    state_e             r_state;
    logic               r_mult_en;
    logic               r_div_en;
    logic               r_ready_id;
    logic               r_wb_valid;
    logic               r_busy;
    logic               r_drop;
    logic [31:0]        r_wb_data;
    logic [RdWidth-1:0] r_wb_rd;
    logic [31:0]        r_op_a;
    logic [31:0]        r_op_b;
    logic [RdWidth-1:0] r_rd;
    logic [1:0]         r_operator;
    logic [1:0]         r_signed_mode;
    logic [67:0]        r_imd_val;

    logic               w_accept;
    logic [3:0]         w_dec;
    logic               w_rd_zero;
    logic               w_is_mult_req;

    // A new request may enter from IDLE, or from RESP in the cycle the result drains.
    assign req_ready_o   = ~flush_i & ((r_state == IDLE) | ((r_state == RESP) & wb_ready_i));
    assign w_accept      = req_valid_i & req_ready_o;
    assign w_dec         = decode_funct3(req_funct3_i);
    assign w_is_mult_req = ~req_funct3_i[2];
    assign w_rd_zero     = (r_rd == {RdWidth{1'b0}});

    // Control FSM; all handshake and enable outputs are registered here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_mult_en  <= 1'b0;
            r_div_en   <= 1'b0;
            r_ready_id <= 1'b0;
            r_wb_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_drop     <= 1'b0;
            r_wb_data  <= 32'h0000_0000;
            r_wb_rd    <= {RdWidth{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state    <= BUSY;
                        r_mult_en  <= w_is_mult_req;
                        r_div_en   <= ~w_is_mult_req;
                        r_ready_id <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    // Enables stay up through a flush so multdiv walks back to its idle state.
                    if (md_valid_i) begin
                        r_mult_en  <= 1'b0;
                        r_div_en   <= 1'b0;
                        r_ready_id <= 1'b0;
                        r_drop     <= 1'b0;
                        if (r_drop | flush_i | (DropRdZero & w_rd_zero)) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= RESP;
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= md_result_i;
                            r_wb_rd    <= r_rd;
                        end
                    end else if (flush_i) begin
                        r_drop <= 1'b1;
                    end
                end
                RESP: begin
                    if (flush_i) begin
                        r_state    <= IDLE;
                        r_wb_valid <= 1'b0;
                        r_busy     <= 1'b0;
                    end else if (wb_ready_i) begin
                        r_wb_valid <= 1'b0;
                        if (w_accept) begin
                            r_state    <= BUSY;
                            r_mult_en  <= w_is_mult_req;
                            r_div_en   <= ~w_is_mult_req;
                            r_ready_id <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_mult_en  <= 1'b0;
                    r_div_en   <= 1'b0;
                    r_ready_id <= 1'b0;
                    r_wb_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_drop     <= 1'b0;
                end
            endcase
        end
    end

    // Request capture: operands, destination and decoded operation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op_a        <= 32'h0000_0000;
            r_op_b        <= 32'h0000_0000;
            r_rd          <= {RdWidth{1'b0}};
            r_operator    <= 2'b00;
            r_signed_mode <= 2'b00;
        end else if (w_accept) begin
            r_op_a        <= req_op_a_i;
            r_op_b        <= req_op_b_i;
            r_rd          <= req_rd_i;
            r_operator    <= w_dec[3:2];
            r_signed_mode <= w_dec[1:0];
        end
    end

    // Intermediate-value storage; each half has its own write enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_imd_val <= 68'h0;
        end else begin
            if (md_imd_val_we_i[0]) begin
                r_imd_val[34+:34] <= md_imd_val_d_i[34+:34];
            end
            if (md_imd_val_we_i[1]) begin
                r_imd_val[0+:34] <= md_imd_val_d_i[0+:34];
            end
        end
    end

    assign md_mult_en_o     = r_mult_en;
    assign md_div_en_o      = r_div_en;
    assign md_mult_sel_o    = r_mult_en;
    assign md_div_sel_o     = r_div_en;
    assign md_operator_o    = r_operator;
    assign md_signed_mode_o = r_signed_mode;
    assign md_op_a_o        = r_op_a;
    assign md_op_b_o        = r_op_b;
    assign md_imd_val_q_o   = r_imd_val;
    assign md_ready_id_o    = r_ready_id;
    assign wb_valid_o       = r_wb_valid;
    assign wb_rd_o          = r_wb_rd;
    assign wb_data_o        = r_wb_data;
    assign busy_o           = r_busy;

endmodule

// File: tb/tb_ibex_md_issue_ctrl.sv
// Directed bench for ibex_md_issue_ctrl; the bench plays the multdiv unit,
// raising md_valid_i a fixed number of enabled cycles after each issue.
module tb_ibex_md_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_op_a;
    logic [31:0] req_op_b;
    logic [4:0]  req_rd;
    logic        flush;
    logic        mult_en;
    logic        div_en;
    logic        mult_sel;
    logic        div_sel;
    logic [1:0]  operator;
    logic [1:0]  signed_mode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [67:0] imd_d;
    logic [1:0]  imd_we;
    logic [67:0] imd_q;
    logic        ready_id;
    logic [31:0] md_result;
    logic        md_valid;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    ibex_md_issue_ctrl #(.RdWidth(5), .DropRdZero(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_funct3_i(req_funct3),
        .req_op_a_i(req_op_a), .req_op_b_i(req_op_b), .req_rd_i(req_rd), .flush_i(flush),
        .md_mult_en_o(mult_en), .md_div_en_o(div_en), .md_mult_sel_o(mult_sel),
        .md_div_sel_o(div_sel), .md_operator_o(operator), .md_signed_mode_o(signed_mode),
        .md_op_a_o(op_a), .md_op_b_o(op_b), .md_imd_val_d_i(imd_d), .md_imd_val_we_i(imd_we),
        .md_imd_val_q_o(imd_q), .md_ready_id_o(ready_id), .md_result_i(md_result),
        .md_valid_i(md_valid), .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
        .wb_rd_o(wb_rd), .wb_data_o(wb_data), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_op_a   = a;
        req_op_b   = b;
        req_rd     = rd;
        #1;
        chk("issue_req_ready", 68'(req_ready), 68'h1);
        tick();
        req_valid = 1'b0;
    endtask

    // Holds the op in BUSY for lat cycles, asserting md_valid_i in the last one.
    task automatic finish_op(input int lat, input logic [31:0] res);
        for (int k = 1; k <= lat; k++) begin
            chk("run_busy", 68'(busy), 68'h1);
            chk("run_wb_valid", 68'(wb_valid), 68'h0);
            chk("run_ready_id", 68'(ready_id), 68'h1);
            chk("run_req_ready", 68'(req_ready), 68'h0);
            if (k == lat) begin
                md_valid  = 1'b1;
                md_result = res;
            end
            tick();
            md_valid = 1'b0;
        end
    endtask

    task automatic run_simple(input string nm, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd, input int lat,
                              input logic is_mult, input logic [1:0] exp_op,
                              input logic [1:0] exp_sm, input logic [31:0] exp_data);
        issue(f3, a, b, rd);
        chk({nm, "_mult_en"}, 68'(mult_en), 68'(is_mult));
        chk({nm, "_div_en"}, 68'(div_en), 68'(!is_mult));
        chk({nm, "_mult_sel"}, 68'(mult_sel), 68'(is_mult));
        chk({nm, "_div_sel"}, 68'(div_sel), 68'(!is_mult));
        chk({nm, "_operator"}, 68'(operator), 68'(exp_op));
        chk({nm, "_signed"}, 68'(signed_mode), 68'(exp_sm));
        chk({nm, "_op_a"}, 68'(op_a), 68'(a));
        chk({nm, "_op_b"}, 68'(op_b), 68'(b));
        finish_op(lat, exp_data);
        chk({nm, "_wb_valid"}, 68'(wb_valid), 68'h1);
        chk({nm, "_wb_data"}, 68'(wb_data), 68'(exp_data));
        chk({nm, "_wb_rd"}, 68'(wb_rd), 68'(rd));
        chk({nm, "_en_off"}, 68'({mult_en, div_en}), 68'h0);
        tick();
        chk({nm, "_wb_pulse"}, 68'(wb_valid), 68'h0);
        chk({nm, "_idle"}, 68'(busy), 68'h0);
        chk({nm, "_ready_again"}, 68'(req_ready), 68'h1);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_funct3 = 3'b000;
        req_op_a   = 32'h0;
        req_op_b   = 32'h0;
        req_rd     = 5'd0;
        flush      = 1'b0;
        imd_d      = 68'h0;
        imd_we     = 2'b00;
        md_result  = 32'h0;
        md_valid   = 1'b0;
        wb_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req_ready", 68'(req_ready), 68'h1);
        chk("rst_busy", 68'(busy), 68'h0);
        chk("rst_wb_valid", 68'(wb_valid), 68'h0);
        chk("rst_enables", 68'({mult_en, div_en, mult_sel, div_sel, ready_id}), 68'h0);
        chk("rst_decode", 68'({operator, signed_mode}), 68'h0);
        chk("rst_ops", 68'({op_a, op_b}), 68'h0);
        chk("rst_wb", 68'({wb_rd, wb_data}), 68'h0);
        chk("rst_imd", imd_q, 68'h0);
        rst_n = 1'b1;
        tick();

        // imd_val halves: we[0] writes the upper half, we[1] the lower half
        imd_d  = {34'h2AAAA5555, 34'h112345678};
        imd_we = 2'b01;
        tick();
        chk("imd_we0", imd_q, {34'h2AAAA5555, 34'h000000000});
        imd_d  = {34'h3FFFF0000, 34'h00F0FF0F0};
        imd_we = 2'b10;
        tick();
        chk("imd_we1", imd_q, {34'h2AAAA5555, 34'h00F0FF0F0});
        imd_d  = {34'h123456789, 34'h39876ABCD};
        imd_we = 2'b11;
        tick();
        chk("imd_we11", imd_q, {34'h123456789, 34'h39876ABCD});
        imd_d  = 68'h0;
        imd_we = 2'b00;
        tick();
        chk("imd_hold", imd_q, {34'h123456789, 34'h39876ABCD});

        run_simple("mul",    3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd3,  3, 1'b1, 2'd0, 2'b00, 32'hFFFFFFEB);
        run_simple("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd4,  3, 1'b1, 2'd1, 2'b11, 32'h40000000);
        run_simple("mulhu",  3'b011, 32'h80000000, 32'h80000000, 5'd6,  3, 1'b1, 2'd1, 2'b00, 32'h40000000);
        run_simple("mulhsu", 3'b010, 32'hFFFFFFFF, 32'h00000002, 5'd8,  3, 1'b1, 2'd1, 2'b01, 32'hFFFFFFFF);
        run_simple("divu",   3'b101, 32'd100,      32'd7,        5'd10, 8, 1'b0, 2'd2, 2'b00, 32'd14);
        run_simple("rem",    3'b110, 32'hFFFFFFF9, 32'h00000002, 5'd11, 8, 1'b0, 2'd3, 2'b11, 32'hFFFFFFFF);
        run_simple("div0",   3'b100, 32'h12345678, 32'h00000000, 5'd12, 8, 1'b0, 2'd2, 2'b11, 32'hFFFFFFFF);
        run_simple("rem0",   3'b110, 32'h00000005, 32'h00000000, 5'd13, 8, 1'b0, 2'd3, 2'b11, 32'h00000005);
        run_simple("remu",   3'b111, 32'd50,       32'd7,        5'd14, 8, 1'b0, 2'd3, 2'b00, 32'd1);

        // writeback stall holds the result
        wb_ready = 1'b0;
        issue(3'b101, 32'd100, 32'd7, 5'd9);
        finish_op(6, 32'd14);
        for (int k = 0; k < 5; k++) begin
            chk("stall_wb_valid", 68'(wb_valid), 68'h1);
            chk("stall_wb_data", 68'(wb_data), 68'd14);
            chk("stall_wb_rd", 68'(wb_rd), 68'd9);
            chk("stall_req_ready", 68'(req_ready), 68'h0);
            tick();
        end
        wb_ready = 1'b1;
        #1;
        chk("stall_release_ready", 68'(req_ready), 68'h1);
        chk("stall_release_valid", 68'(wb_valid), 68'h1);
        tick();
        chk("stall_drained", 68'({wb_valid, busy}), 68'h0);

        // flush in IDLE blocks a coincident request
        flush     = 1'b1;
        req_valid = 1'b1;
        req_funct3 = 3'b000;
        #1;
        chk("flush_idle_ready", 68'(req_ready), 68'h0);
        tick();
        chk("flush_idle_busy", 68'(busy), 68'h0);
        flush     = 1'b0;
        req_valid = 1'b0;

        // flush three cycles into a DIV: drain silently, then a fresh MUL
        issue(3'b100, 32'd100, 32'd3, 5'd7);
        tick();
        tick();
        flush = 1'b1;
        #1;
        chk("flush_busy_ready", 68'(req_ready), 68'h0);
        tick();
        flush = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk("drain_div_en", 68'(div_en), 68'h1);
            chk("drain_busy", 68'(busy), 68'h1);
            chk("drain_wb_valid", 68'(wb_valid), 68'h0);
            chk("drain_req_ready", 68'(req_ready), 68'h0);
            if (k == 6) begin
                md_valid  = 1'b1;
                md_result = 32'd33;
            end
            tick();
            md_valid = 1'b0;
        end
        chk("drained_state", 68'({busy, wb_valid, div_en, mult_en}), 68'h0);
        run_simple("mul_after_flush", 3'b000, 32'd3, 32'd4, 5'd2, 3, 1'b1, 2'd0, 2'b00, 32'd12);

        // flush coincident with md_valid in BUSY
        issue(3'b100, 32'd9, 32'd3, 5'd1);
        tick();
        flush     = 1'b1;
        md_valid  = 1'b1;
        md_result = 32'd3;
        tick();
        flush    = 1'b0;
        md_valid = 1'b0;
        chk("flush_valid_same", 68'({busy, wb_valid, div_en}), 68'h0);

        // flush in RESP drops wb_valid
        wb_ready = 1'b0;
        issue(3'b000, 32'd5, 32'd5, 5'd15);
        finish_op(3, 32'd25);
        chk("resp_flush_pre", 68'(wb_valid), 68'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("resp_flush_post", 68'({wb_valid, busy}), 68'h0);
        wb_ready = 1'b1;

        // back-to-back: rd=5 writes back, rd=0 completes silently
        issue(3'b000, 32'd2, 32'd3, 5'd5);
        finish_op(3, 32'd6);
        chk("b2b_wb_valid", 68'(wb_valid), 68'h1);
        chk("b2b_wb_rd", 68'(wb_rd), 68'd5);
        chk("b2b_wb_data", 68'(wb_data), 68'd6);
        req_valid  = 1'b1;
        req_funct3 = 3'b000;
        req_op_a   = 32'd9;
        req_op_b   = 32'd9;
        req_rd     = 5'd0;
        #1;
        chk("b2b_req_ready", 68'(req_ready), 68'h1);
        tick();
        req_valid = 1'b0;
        chk("b2b_no_bubble", 68'({busy, mult_en, wb_valid}), 68'b110);
        chk("b2b_op_a", 68'(op_a), 68'd9);
        finish_op(3, 32'd81);
        chk("b2b_silent", 68'({wb_valid, busy, mult_en}), 68'h0);

        // asynchronous reset in the middle of an operation
        imd_d  = {34'h155555555, 34'h0AAAAAAAA};
        imd_we = 2'b11;
        issue(3'b000, 32'd7, 32'd8, 5'd3);
        imd_we = 2'b00;
        chk("pre_rst_busy", 68'(busy), 68'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 68'({busy, mult_en, ready_id}), 68'h0);
        chk("mid_rst_ready", 68'(req_ready), 68'h1);
        chk("mid_rst_imd", imd_q, 68'h0);
        chk("mid_rst_op_a", 68'(op_a), 68'h0);
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
